// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM byte loader: FSM encoding and byte/word sizing.
package ram_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int bytes_per_word(input int data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/ram_loader_word_packer.sv
// Assembles a word from a byte stream, LSB byte first, via a right-shifting register.
module ram_loader_word_packer
  import ram_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  accept,
  input  logic                  clear,
  input  logic [BYTE_W-1:0]     byte_in,
  output logic [DATA_WIDTH-1:0] word_next,
  output logic                  word_ready
);

  localparam int BPW   = bytes_per_word(DATA_WIDTH);
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CNT_W-1:0]      byte_cnt;
  logic [DATA_WIDTH-1:0] word_q;

  // New bytes enter at the top, so after BPW shifts byte 0 sits in the LSBs.
  generate
    if (BPW == 1) begin : g_single
      always_comb begin
        word_next = word_q;
        if (accept) word_next = byte_in;
      end
    end else begin : g_multi
      always_comb begin
        word_next = word_q;
        if (accept) word_next = {byte_in, word_q[DATA_WIDTH-1:BYTE_W]};
      end
    end
  endgenerate

  assign word_ready = accept && (byte_cnt == CNT_W'(BPW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (accept) begin
      byte_cnt <= word_ready ? '0 : byte_cnt + CNT_W'(1);
      word_q   <= word_next;
    end
  end

endmodule

// File: rtl/ram_byte_loader.sv
// Byte-stream to RAM write-port loader with range checking and status outputs.
// Optional running word checksum on oChecksum when RAM_LOADER_CHECKSUM_EN is defined.
module ram_byte_loader
  import ram_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_SIZE   = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic                  iAbort,
  input  logic [ADDR_WIDTH-1:0] iBaseAddress,
  input  logic [ADDR_WIDTH-1:0] iWordCount,
  input  logic                  iByteValid,
  input  logic [BYTE_W-1:0]     iByte,
  output logic                  oByteReady,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oDataOut,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oError,
  output logic [DATA_WIDTH-1:0] oChecksum
);

  localparam int AW1 = ADDR_WIDTH + 1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, remaining;
  logic [AW1-1:0]        last_addr;
  logic                  range_err, start_ok, accept, word_ready;
  logic [DATA_WIDTH-1:0] word_next;

  // Extra bit keeps base+count-1 from wrapping back into range.
  assign last_addr = {1'b0, iBaseAddress} + {1'b0, iWordCount} - AW1'(1);
  assign range_err = last_addr > AW1'(MEM_SIZE);
  assign start_ok  = (state == IDLE) && iStart && !iAbort;
  assign accept    = (state == COLLECT) && oByteReady && iByteValid && !iAbort;

  ram_loader_word_packer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_packer (
    .clk       (Clock),
    .rst_n     (Reset),
    .accept    (accept),
    .clear     (start_ok || iAbort),
    .byte_in   (iByte),
    .word_next (word_next),
    .word_ready(word_ready)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          if (iWordCount == '0 || range_err) state_nxt = DONE;
          else                               state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (iAbort)          state_nxt = IDLE;
        else if (word_ready) state_nxt = WRITE;
      end
      WRITE: begin
        if (iAbort)                              state_nxt = IDLE;
        else if (remaining == ADDR_WIDTH'(1))    state_nxt = DONE;
        else                                     state_nxt = COLLECT;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oByteReady    <= 1'b0;
      oWriteEnable  <= 1'b0;
      oWriteAddress <= '0;
      oDataOut      <= '0;
      oBusy         <= 1'b0;
      oDone         <= 1'b0;
      oError        <= 1'b0;
      addr          <= '0;
      remaining     <= '0;
    end else begin
      oByteReady   <= (state_nxt == COLLECT);
      oWriteEnable <= (state_nxt == WRITE);
      oBusy        <= (state_nxt != IDLE);
      oDone        <= (state_nxt == DONE);
      if (start_ok) begin
        addr      <= iBaseAddress;
        remaining <= iWordCount;
        oError    <= (iWordCount != '0) && range_err;
      end
      if (state_nxt == WRITE) begin
        oWriteAddress <= addr;
        oDataOut      <= word_next;
      end
      if (state == WRITE) begin
        addr      <= addr + ADDR_WIDTH'(1);
        remaining <= remaining - ADDR_WIDTH'(1);
      end
    end
  end

`ifdef RAM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)                  checksum <= '0;
    else if (start_ok)           checksum <= '0;
    else if (state_nxt == WRITE) checksum <= checksum + word_next;
  end

  assign oChecksum = checksum;
`else
  assign oChecksum = '0;
`endif

endmodule

// File: tb/tb_ram_byte_loader.sv
// Directed self-checking bench for ram_byte_loader with a RAM/write-log monitor.
module tb_ram_byte_loader;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int MS = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          iStart = 1'b0;
  logic          iAbort = 1'b0;
  logic [AW-1:0] iBaseAddress = '0;
  logic [AW-1:0] iWordCount = '0;
  logic          iByteValid = 1'b0;
  logic [7:0]    iByte = '0;
  logic          oByteReady, oWriteEnable, oBusy, oDone, oError;
  logic [AW-1:0] oWriteAddress;
  logic [DW-1:0] oDataOut, oChecksum;

  ram_byte_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iAbort(iAbort),
    .iBaseAddress(iBaseAddress), .iWordCount(iWordCount),
    .iByteValid(iByteValid), .iByte(iByte), .oByteReady(oByteReady),
    .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress),
    .oDataOut(oDataOut), .oBusy(oBusy), .oDone(oDone), .oError(oError),
    .oChecksum(oChecksum)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nwr = 0;
  int ndone = 0;
  int done_cyc = 0;
  int nrdy_we = 0;
  logic [DW-1:0] ram   [0:MS];
  logic [AW-1:0] waddr [0:63];
  logic [DW-1:0] wdata [0:63];
  int            wcyc  [0:63];
  logic [7:0]    stream [0:7];

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (oWriteEnable) begin
      if (oWriteAddress <= AW'(MS)) ram[oWriteAddress] = oDataOut;
      if (nwr < 64) begin
        waddr[nwr] = oWriteAddress;
        wdata[nwr] = oDataOut;
        wcyc[nwr]  = cyc;
      end
      nwr++;
    end
    if (oDone) begin
      ndone++;
      done_cyc = cyc;
    end
    if (oWriteEnable && oByteReady) nrdy_we++;
  end

  task automatic settle(input int n);
    repeat (n) @(negedge Clock);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] base, input logic [AW-1:0] cnt, output int start_cyc);
    @(negedge Clock);
    start_cyc = cyc;
    iBaseAddress = base;
    iWordCount = cnt;
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
  endtask

  // Offers stream[0..n-1]; a byte advances only on a cycle with ready and valid.
  task automatic feed(input int n, input bit toggle);
    int i = 0;
    int k = 0;
    logic rdy;
    while (i < n && k < 200) begin
      if (toggle && (k % 2 == 1)) iByteValid = 1'b0;
      else begin
        iByteValid = 1'b1;
        iByte = stream[i];
      end
      rdy = oByteReady;
      @(posedge Clock);
      if (rdy && iByteValid) i++;
      k++;
      @(negedge Clock);
    end
    iByteValid = 1'b0;
    if (i < n) begin
      errors++;
      $display("FAIL feed_timeout accepted %0d bytes, required %0d", i, n);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({oByteReady, oWriteEnable, oWriteAddress, oDataOut, oBusy, oDone, oError, oChecksum} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b rdy=%b we=%b addr=%h data=%h done=%b err=%b", oBusy, oByteReady, oWriteEnable, oWriteAddress, oDataOut, oDone, oError);
    end
    @(negedge Clock);
    Reset = 1'b1;
    settle(2);
  endtask

  task automatic test_basic_load();
    int w0, d0, sc;
    logic [DW-1:0] exp_sum;
    w0 = nwr; d0 = ndone;
    stream[0] = 8'h34; stream[1] = 8'h12; stream[2] = 8'h78;
    stream[3] = 8'h56; stream[4] = 8'hBC; stream[5] = 8'h9A;
    do_start(8'd2, 8'd3, sc);
    feed(6, 1'b0);
    settle(4);
    checks++; if (ram[2] !== 16'h1234) begin errors++; $display("FAIL basic_ram2 got %h expected 1234", ram[2]); end
    checks++; if (ram[3] !== 16'h5678) begin errors++; $display("FAIL basic_ram3 got %h expected 5678", ram[3]); end
    checks++; if (ram[4] !== 16'h9ABC) begin errors++; $display("FAIL basic_ram4 got %h expected 9abc", ram[4]); end
    checks++; if (nwr - w0 !== 3) begin errors++; $display("FAIL basic_writes got %0d expected 3", nwr - w0); end
    checks++; if (wcyc[w0+1] - wcyc[w0] !== 3) begin errors++; $display("FAIL basic_spacing01 got %0d expected 3", wcyc[w0+1] - wcyc[w0]); end
    checks++; if (wcyc[w0+2] - wcyc[w0+1] !== 3) begin errors++; $display("FAIL basic_spacing12 got %0d expected 3", wcyc[w0+2] - wcyc[w0+1]); end
    checks++; if (ndone - d0 !== 1 || done_cyc - wcyc[w0+2] !== 1) begin errors++; $display("FAIL basic_done got pulses=%0d gap=%0d expected 1 and 1", ndone - d0, done_cyc - wcyc[w0+2]); end
    checks++; if (oError !== 1'b0 || oBusy !== 1'b0) begin errors++; $display("FAIL basic_status got err=%b busy=%b expected 0 0", oError, oBusy); end
`ifdef RAM_LOADER_CHECKSUM_EN
    exp_sum = 16'h0368;
`else
    exp_sum = 16'h0000;
`endif
    checks++; if (oChecksum !== exp_sum) begin errors++; $display("FAIL basic_checksum got %h expected %h", oChecksum, exp_sum); end
  endtask

  task automatic test_stall();
    int w0, d0, sc;
    logic [DW-1:0] exp_d [0:2];
    exp_d[0] = 16'h1234; exp_d[1] = 16'h5678; exp_d[2] = 16'h9ABC;
    w0 = nwr; d0 = ndone; nrdy_we = 0;
    do_start(8'd2, 8'd3, sc);
    feed(6, 1'b1);
    settle(4);
    checks++; if (nwr - w0 !== 3) begin errors++; $display("FAIL stall_writes got %0d expected 3", nwr - w0); end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (waddr[w0+j] !== AW'(2 + j) || wdata[w0+j] !== exp_d[j]) begin
        errors++;
        $display("FAIL stall_word%0d got %h@%h expected %h@%h", j, wdata[w0+j], waddr[w0+j], exp_d[j], AW'(2 + j));
      end
    end
    checks++; if (nrdy_we !== 0) begin errors++; $display("FAIL stall_ready_in_write got %0d cycles expected 0", nrdy_we); end
    checks++; if (ndone - d0 !== 1) begin errors++; $display("FAIL stall_done got %0d expected 1", ndone - d0); end
  endtask

  task automatic test_range_error();
    int w0, d0, sc;
    w0 = nwr; d0 = ndone;
    do_start(8'd7, 8'd3, sc);
    settle(4);
    checks++; if (oError !== 1'b1) begin errors++; $display("FAIL range_error got %b expected 1", oError); end
    checks++; if (ndone - d0 !== 1 || nwr - w0 !== 0) begin errors++; $display("FAIL range_done got done=%0d writes=%0d expected 1 0", ndone - d0, nwr - w0); end
    do_start(8'd0, 8'd1, sc);
    checks++; if (oError !== 1'b0) begin errors++; $display("FAIL range_clear got %b expected 0", oError); end
    stream[0] = 8'hEF; stream[1] = 8'hBE;
    feed(2, 1'b0);
    settle(3);
    checks++; if (ram[0] !== 16'hBEEF) begin errors++; $display("FAIL range_followup got %h expected beef", ram[0]); end
  endtask

  task automatic test_zero_count();
    int w0, d0, sc;
    w0 = nwr; d0 = ndone;
    do_start(8'd1, 8'd0, sc);
    settle(3);
    checks++; if (ndone - d0 !== 1 || nwr - w0 !== 0) begin errors++; $display("FAIL zero_done got done=%0d writes=%0d expected 1 0", ndone - d0, nwr - w0); end
    checks++; if (done_cyc - sc < 1 || done_cyc - sc > 2) begin errors++; $display("FAIL zero_latency got %0d expected 1..2", done_cyc - sc); end
    checks++; if (oError !== 1'b0) begin errors++; $display("FAIL zero_error got %b expected 0", oError); end
  endtask

  task automatic test_abort_reset();
    int w0, d0, sc;
    w0 = nwr; d0 = ndone;
    stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33;
    do_start(8'd0, 8'd3, sc);
    feed(3, 1'b0);
    iAbort = 1'b1;
    @(negedge Clock);
    iAbort = 1'b0;
    settle(4);
    checks++; if (nwr - w0 !== 1 || ndone - d0 !== 0) begin errors++; $display("FAIL abort_effect got writes=%0d done=%0d expected 1 0", nwr - w0, ndone - d0); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b expected 0", oBusy); end
    w0 = nwr; d0 = ndone;
    do_start(8'd0, 8'd2, sc);
    feed(1, 1'b0);
    @(posedge Clock);
    #2 Reset = 1'b0;
    #1;
    checks++;
    if ({oByteReady, oWriteEnable, oWriteAddress, oDataOut, oBusy, oDone, oError, oChecksum} !== '0) begin
      errors++;
      $display("FAIL midload_reset got busy=%b rdy=%b we=%b addr=%h data=%h done=%b", oBusy, oByteReady, oWriteEnable, oWriteAddress, oDataOut, oDone);
    end
    @(negedge Clock);
    Reset = 1'b1;
    settle(3);
    checks++; if (nwr - w0 !== 0 || ndone - d0 !== 0) begin errors++; $display("FAIL midload_after got writes=%0d done=%0d expected 0 0", nwr - w0, ndone - d0); end
    stream[0] = 8'h11; stream[1] = 8'h22;
    do_start(8'd5, 8'd1, sc);
    feed(2, 1'b0);
    settle(3);
    checks++; if (ram[5] !== 16'h2211) begin errors++; $display("FAIL post_reset_word got %h expected 2211", ram[5]); end
  endtask

  task automatic test_checksum();
    int sc;
    logic [DW-1:0] exp_sum;
    stream[0] = 8'hFF; stream[1] = 8'hFF; stream[2] = 8'h02; stream[3] = 8'h00;
    do_start(8'd0, 8'd2, sc);
    feed(4, 1'b0);
    settle(4);
`ifdef RAM_LOADER_CHECKSUM_EN
    exp_sum = 16'h0001;
`else
    exp_sum = 16'h0000;
`endif
    checks++; if (oChecksum !== exp_sum) begin errors++; $display("FAIL checksum got %h expected %h", oChecksum, exp_sum); end
    checks++; if (ram[0] !== 16'hFFFF || ram[1] !== 16'h0002) begin errors++; $display("FAIL checksum_words got %h %h expected ffff 0002", ram[0], ram[1]); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_stall();
    test_range_error();
    test_zero_count();
    test_abort_reset();
    test_checksum();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
